// File: rtl/pkt_mux.sv
`default_nettype none
// ============================================================================
// Module   : pkt_mux
// Purpose  : Merges two 134-bit packet streams (input 0 = local transmit,
//            input 1 = forwarding) into the single stream entering the switch
//            core. Each input is buffered per packet. Only whole packets whose
//            status is good are forwarded, and packets are never interleaved.
//            Word tag in [133:132]: 01 first, 11 middle, 10 last.
// Ports    : clk, rst_n (synchronous, active-low)
//            inN_data_wr / inN_data / inN_data_valid / inN_data_valid_wr
//              - word strobe, word, packet status, status strobe (N = 0, 1)
//            inN_alf          - almost full, registered
//            pktout_data_wr / pktout_data / pktout_data_valid /
//            pktout_data_valid_wr - registered output stream
//            pktout_ready     - downstream may accept a word this cycle
//            out_pkt_cnt      - number of packets forwarded (wraps)
// Options  : PKT_MUX_PRIO_EN - when defined, input 0 wins every arbitration
//            it is eligible for; otherwise round-robin between the inputs.
// Revision : 1.0 - initial release
// ============================================================================
module pkt_mux #(
    parameter int DFIFO_AW   = 8,
    parameter int PFIFO_AW   = 4,
    parameter int ALF_MARGIN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in0_data_wr,
    input  logic [133:0] in0_data,
    input  logic         in0_data_valid,
    input  logic         in0_data_valid_wr,
    output logic         in0_alf,
    input  logic         in1_data_wr,
    input  logic [133:0] in1_data,
    input  logic         in1_data_valid,
    input  logic         in1_data_valid_wr,
    output logic         in1_alf,
    output logic         pktout_data_wr,
    output logic [133:0] pktout_data,
    output logic         pktout_data_valid,
    output logic         pktout_data_valid_wr,
    input  logic         pktout_ready,
    output logic [31:0]  out_pkt_cnt
);

    localparam int                c_DDEPTH   = 1 << DFIFO_AW;
    localparam int                c_SDEPTH   = 1 << PFIFO_AW;
    localparam logic [DFIFO_AW:0] c_DFULL    = (DFIFO_AW + 1)'(c_DDEPTH);
    // free <= margin is the same as count >= depth - margin
    localparam logic [DFIFO_AW:0] c_DALF     = (DFIFO_AW + 1)'(c_DDEPTH - ALF_MARGIN);
    localparam logic [PFIFO_AW:0] c_SFULL    = (PFIFO_AW + 1)'(c_SDEPTH);
    localparam logic [PFIFO_AW:0] c_SALF     = (PFIFO_AW + 1)'(c_SDEPTH - 2);
    localparam logic [1:0]        c_TAG_LAST = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    // Per-input views so both buffers come from one generate body
    logic [1:0]        in_wr;
    logic [1:0]        in_v;
    logic [1:0]        in_vwr;
    logic [1:0][133:0] in_word;
    logic [1:0][133:0] d_head;
    logic [1:0]        d_nempty;
    logic [1:0]        s_nempty;
    logic [1:0]        s_head;
    logic [1:0]        alf;
    logic [1:0]        d_pop;
    logic [1:0]        s_pop;

    assign in_wr   = {in1_data_wr, in0_data_wr};
    assign in_v    = {in1_data_valid, in0_data_valid};
    assign in_vwr  = {in1_data_valid_wr, in0_data_valid_wr};
    assign in_word = {in1_data, in0_data};
    assign in0_alf = alf[0];
    assign in1_alf = alf[1];

    for (genvar i = 0; i < 2; i++) begin : g_in
        logic [133:0]        dmem [c_DDEPTH];
        logic [DFIFO_AW-1:0] dwp_q, dwp_d, drp_q, drp_d;
        logic [DFIFO_AW:0]   dcnt_q, dcnt_d;
        logic [c_SDEPTH-1:0] smem_q, smem_d;
        logic [PFIFO_AW-1:0] swp_q, swp_d, srp_q, srp_d;
        logic [PFIFO_AW:0]   scnt_q, scnt_d;
        logic                alf_q, alf_d;
        logic                d_push;
        logic                s_push;

        always_comb begin
            // Pushes into a full FIFO are dropped; pops are pre-qualified by the FSM
            d_push = in_wr[i] && (dcnt_q != c_DFULL);
            s_push = in_vwr[i] && (scnt_q != c_SFULL);
            dwp_d  = dwp_q + DFIFO_AW'(d_push);
            drp_d  = drp_q + DFIFO_AW'(d_pop[i]);
            dcnt_d = dcnt_q + (DFIFO_AW + 1)'(d_push) - (DFIFO_AW + 1)'(d_pop[i]);
            smem_d = smem_q;
            if (s_push) begin
                smem_d[swp_q] = in_v[i];
            end
            swp_d  = swp_q + PFIFO_AW'(s_push);
            srp_d  = srp_q + PFIFO_AW'(s_pop[i]);
            scnt_d = scnt_q + (PFIFO_AW + 1)'(s_push) - (PFIFO_AW + 1)'(s_pop[i]);
            // Registered from the current counts, so it trails a count change by one clock
            alf_d  = (dcnt_q >= c_DALF) || (scnt_q >= c_SALF);
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                dwp_q  <= '0;
                drp_q  <= '0;
                dcnt_q <= '0;
                smem_q <= '0;
                swp_q  <= '0;
                srp_q  <= '0;
                scnt_q <= '0;
                alf_q  <= 1'b0;
            end else begin
                dwp_q  <= dwp_d;
                drp_q  <= drp_d;
                dcnt_q <= dcnt_d;
                smem_q <= smem_d;
                swp_q  <= swp_d;
                srp_q  <= srp_d;
                scnt_q <= scnt_d;
                alf_q  <= alf_d;
            end
        end

        // Storage array carries no reset; emptiness is defined by the pointers
        always_ff @(posedge clk) begin
            if (d_push) begin
                dmem[dwp_q] <= in_word[i];
            end
        end

        assign d_head[i]   = dmem[drp_q];
        assign s_head[i]   = smem_q[srp_q];
        assign d_nempty[i] = (dcnt_q != '0);
        assign s_nempty[i] = (scnt_q != '0);
        assign alf[i]      = alf_q;
    end

    // ------------------------------------------------------------------------
    // Arbiter / output FSM
    // ------------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          sel_q, sel_d;
    logic          rr_q, rr_d;
    logic          out_wr_q, out_wr_d;
    logic [133:0]  out_data_q, out_data_d;
    logic          out_v_q, out_v_d;
    logic          out_vwr_q, out_vwr_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          pick;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rr_d       = rr_q;
        out_wr_d   = 1'b0;
        out_data_d = out_data_q;
        out_v_d    = 1'b0;
        out_vwr_d  = 1'b0;
        cnt_d      = cnt_q;
        d_pop      = '0;
        s_pop      = '0;
        pick       = 1'b0;

`ifdef PKT_MUX_PRIO_EN
        pick = !s_nempty[0];
`else
        // With one contender take it, with two follow the pointer
        pick = (&s_nempty) ? rr_q : s_nempty[1];
`endif

        case (state_q)
            ST_IDLE: begin
                if (pktout_ready && (s_nempty != 2'b00)) begin
                    s_pop[pick] = 1'b1;
                    sel_d       = pick;
                    state_d     = s_head[pick] ? ST_SEND : ST_DROP;
                end
            end
            ST_SEND: begin
                if (pktout_ready && d_nempty[sel_q]) begin
                    d_pop[sel_q] = 1'b1;
                    out_wr_d     = 1'b1;
                    out_data_d   = d_head[sel_q];
                    if (d_head[sel_q][133:132] == c_TAG_LAST) begin
                        out_v_d   = 1'b1;
                        out_vwr_d = 1'b1;
                        cnt_d     = cnt_q + 32'd1;
                        rr_d      = ~sel_q;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                // Bad packets drain regardless of downstream readiness
                if (d_nempty[sel_q]) begin
                    d_pop[sel_q] = 1'b1;
                    if (d_head[sel_q][133:132] == c_TAG_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= 1'b0;
            rr_q       <= 1'b0;
            out_wr_q   <= 1'b0;
            out_data_q <= '0;
            out_v_q    <= 1'b0;
            out_vwr_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rr_q       <= rr_d;
            out_wr_q   <= out_wr_d;
            out_data_q <= out_data_d;
            out_v_q    <= out_v_d;
            out_vwr_q  <= out_vwr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pktout_data_wr       = out_wr_q;
    assign pktout_data          = out_data_q;
    assign pktout_data_valid    = out_v_q;
    assign pktout_data_valid_wr = out_vwr_q;
    assign out_pkt_cnt          = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pkt_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_pkt_mux
// Purpose  : Self-checking bench for pkt_mux. A queue-based packet model
//            predicts every output each cycle; directed scenarios add literal
//            expectations, followed by a randomized two-input traffic phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_mux;

    localparam int c_DDEPTH = 256;
    localparam int c_SDEPTH = 16;
    localparam int c_MARGIN = 32;

    logic         clk;
    logic         rst_n;
    logic         in0_data_wr, in0_data_valid, in0_data_valid_wr, in0_alf;
    logic [133:0] in0_data;
    logic         in1_data_wr, in1_data_valid, in1_data_valid_wr, in1_alf;
    logic [133:0] in1_data;
    logic         pktout_data_wr, pktout_data_valid, pktout_data_valid_wr, pktout_ready;
    logic [133:0] pktout_data;
    logic [31:0]  out_pkt_cnt;

    pkt_mux dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .in0_data_wr         (in0_data_wr),
        .in0_data            (in0_data),
        .in0_data_valid      (in0_data_valid),
        .in0_data_valid_wr   (in0_data_valid_wr),
        .in0_alf             (in0_alf),
        .in1_data_wr         (in1_data_wr),
        .in1_data            (in1_data),
        .in1_data_valid      (in1_data_valid),
        .in1_data_valid_wr   (in1_data_valid_wr),
        .in1_alf             (in1_alf),
        .pktout_data_wr      (pktout_data_wr),
        .pktout_data         (pktout_data),
        .pktout_data_valid   (pktout_data_valid),
        .pktout_data_valid_wr(pktout_data_valid_wr),
        .pktout_ready        (pktout_ready),
        .out_pkt_cnt         (out_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Model state: buffered words/statuses per input, and the packet in flight
    logic [133:0] m_dq [2][$];
    bit           m_sq [2][$];
    logic [133:0] m_pend [$];
    int           m_mode = 0;      // 0 waiting, 1 forwarding, 2 discarding
    bit           m_sel  = 1'b0;
    bit           m_rr   = 1'b0;
    bit           m_wr = 1'b0, m_v = 1'b0, m_vwr = 1'b0;
    logic [133:0] m_data = '0;
    logic [31:0]  m_cnt  = '0;
    logic [1:0]   m_alf  = '0;
    int           stat_cyc = 0;

    logic [133:0] out_words [$];
    int           out_cyc [$];
    int           out_log [$];
    int           first_wr_cyc = -1;
    int           n_good = 0;
    bit           rnd_done = 1'b0;

    task automatic chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Word layout: tag | port[131:128] | pid[127:112] | idx[111:104] | payload
    function automatic logic [133:0] mk_word(input int port, input int pid, input int idx, input int len);
        logic [1:0]  tag;
        logic [31:0] h;
        tag = (idx == 0) ? 2'b01 : ((idx == len - 1) ? 2'b10 : 2'b11);
        h   = 32'(pid) * 32'h9E3779B1 + 32'(idx) * 32'h85EBCA77 + 32'(port);
        return {tag, 4'(port), 16'(pid), 8'(idx), h, ~h, h ^ 32'h5A5A5A5A, h[7:0]};
    endfunction

    task automatic set_in(input int port, input logic wr, input logic [133:0] d, input logic v, input logic vwr);
        if (port == 0) begin
            in0_data_wr = wr; in0_data = d; in0_data_valid = v; in0_data_valid_wr = vwr;
        end else begin
            in1_data_wr = wr; in1_data = d; in1_data_valid = v; in1_data_valid_wr = vwr;
        end
    endtask

    task automatic send_pkt(input int port, input int len, input bit good, input int sdly, input int pid);
        for (int k = 0; k < len; k++) begin
            set_in(port, 1'b1, mk_word(port, pid, k, len), good, (k == len - 1) && (sdly == 0));
            tick();
        end
        set_in(port, 1'b0, '0, 1'b0, 1'b0);
        if (sdly > 0) begin
            repeat (sdly - 1) tick();
            set_in(port, 1'b0, '0, good, 1'b1);
            tick();
            set_in(port, 1'b0, '0, 1'b0, 1'b0);
        end
    endtask

    task automatic wait_cnt(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (out_pkt_cnt < 32'(target) && n < budget) begin
            tick();
            n++;
        end
        chk(name, (out_pkt_cnt >= 32'(target)), 1'b1);
    endtask

    task automatic wait_words(input int target, input string name);
        int n;
        n = 0;
        while (out_words.size() < target && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, (out_words.size() >= target), 1'b1);
    endtask

    task automatic rnd_drv(input int port);
        int  len, sd, gap, w;
        bit  good;
        for (int n = 0; n < 30; n++) begin
            len  = $urandom_range(2, 8);
            good = ($urandom_range(0, 3) != 0);
            sd   = $urandom_range(0, 2);
            gap  = $urandom_range(0, 2);
            w    = 0;
            while (((port == 0) ? in0_alf : in1_alf) && w < 2000) begin
                tick();
                w++;
            end
            chk("rnd_alf_wait", (port == 0) ? in0_alf : in1_alf, 1'b0);
            send_pkt(port, len, good, sd, 100 + port * 100 + n);
            if (good) n_good++;
            repeat (gap) tick();
        end
    endtask

    // Behavioural model: a packet is lifted out of its input buffer whole when
    // chosen, then streamed (good) or discarded (bad) one word per cycle.
    always @(posedge clk) begin : mdl_proc
        int  stored;
        bit  dfull [2];
        bit  sfull [2];
        bit  nalf  [2];
        bit  pick, good;
        logic [133:0] w;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_dq[i].delete();
                m_sq[i].delete();
            end
            m_pend.delete();
            m_mode = 0; m_sel = 0; m_rr = 0;
            m_wr = 0; m_v = 0; m_vwr = 0; m_data = '0; m_cnt = '0; m_alf = '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                stored   = m_dq[i].size() + ((m_sel == i) ? m_pend.size() : 0);
                dfull[i] = (stored >= c_DDEPTH);
                sfull[i] = (m_sq[i].size() >= c_SDEPTH);
                nalf[i]  = (c_DDEPTH - stored <= c_MARGIN) || (m_sq[i].size() >= c_SDEPTH - 2);
            end
            m_wr = 0; m_v = 0; m_vwr = 0;
            if (m_mode == 0) begin
                if (pktout_ready && (m_sq[0].size() + m_sq[1].size() > 0)) begin
`ifdef PKT_MUX_PRIO_EN
                    pick = (m_sq[0].size() == 0);
`else
                    if (m_sq[0].size() > 0 && m_sq[1].size() > 0) pick = m_rr;
                    else pick = (m_sq[0].size() == 0);
`endif
                    good = m_sq[pick].pop_front();
                    while (m_dq[pick].size() > 0) begin
                        w = m_dq[pick].pop_front();
                        m_pend.push_back(w);
                        if (w[133:132] == 2'b10) break;
                    end
                    m_sel  = pick;
                    m_mode = good ? 1 : 2;
                end
            end else if (m_mode == 1) begin
                if (pktout_ready && m_pend.size() > 0) begin
                    m_data = m_pend.pop_front();
                    m_wr   = 1;
                    if (m_pend.size() == 0) begin
                        m_v = 1; m_vwr = 1; m_cnt++; m_rr = ~m_sel; m_mode = 0;
                    end
                end
            end else begin
                if (m_pend.size() > 0) void'(m_pend.pop_front());
                if (m_pend.size() == 0) m_mode = 0;
            end
            if (in0_data_wr && !dfull[0]) m_dq[0].push_back(in0_data);
            if (in1_data_wr && !dfull[1]) m_dq[1].push_back(in1_data);
            if (in0_data_valid_wr && !sfull[0]) begin
                m_sq[0].push_back(in0_data_valid);
                stat_cyc = cyc;
            end
            if (in1_data_valid_wr && !sfull[1]) begin
                m_sq[1].push_back(in1_data_valid);
                stat_cyc = cyc;
            end
            m_alf = {nalf[1], nalf[0]};
        end
    end

    always @(negedge clk) begin : cmp_proc
        if (chk_en) begin
            chk("pktout_data_wr", pktout_data_wr, m_wr);
            chk("pktout_data", pktout_data, m_data);
            chk("pktout_data_valid", pktout_data_valid, m_v);
            chk("pktout_data_valid_wr", pktout_data_valid_wr, m_vwr);
            chk("out_pkt_cnt", out_pkt_cnt, m_cnt);
            chk("in0_alf", in0_alf, m_alf[0]);
            chk("in1_alf", in1_alf, m_alf[1]);
            if (pktout_data_wr) begin
                out_words.push_back(pktout_data);
                out_cyc.push_back(cyc);
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                if (pktout_data_valid_wr) out_log.push_back(int'(pktout_data[127:112]));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int exp_ord [4];
        int base;
        rst_n = 1'b0;
        pktout_ready = 1'b1;
        set_in(0, 1'b0, '0, 1'b0, 1'b0);
        set_in(1, 1'b0, '0, 1'b0, 1'b0);
        repeat (3) tick();
        chk_en = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_data_wr", pktout_data_wr, 1'b0);
        chk("rst_data", pktout_data, '0);
        chk("rst_valid_wr", pktout_data_valid_wr, 1'b0);
        chk("rst_cnt", out_pkt_cnt, '0);
        chk("rst_alf", {in1_alf, in0_alf}, 2'b00);
        rst_n = 1'b1;
        tick();

        // Single good packet on input 0
        first_wr_cyc = -1;
        out_words.delete();
        send_pkt(0, 4, 1'b1, 0, 1);
        wait_cnt(1, 50, "t1_timeout");
        tick();
        chk("t1_cnt", out_pkt_cnt, 32'd1);
        chk("t1_len", out_words.size(), 4);
        for (int k = 0; k < out_words.size(); k++) chk("t1_word", out_words[k], mk_word(0, 1, k, 4));
        chk("t1_latency", first_wr_cyc - stat_cyc, 2);

        // Bad packet on input 1 is dropped; the next good one passes
        out_words.delete();
        send_pkt(1, 3, 1'b0, 1, 2);
        repeat (15) tick();
        chk("t2_cnt_bad", out_pkt_cnt, 32'd1);
        chk("t2_no_words", out_words.size(), 0);
        send_pkt(1, 4, 1'b1, 0, 3);
        wait_cnt(2, 50, "t2_timeout");
        tick();
        chk("t2_cnt_good", out_pkt_cnt, 32'd2);
        chk("t2_word0", out_words[0], mk_word(1, 3, 0, 4));

        // Arbitration order with two packets queued per input
        pktout_ready = 1'b0;
        send_pkt(0, 3, 1'b1, 0, 10);
        send_pkt(0, 2, 1'b1, 0, 11);
        send_pkt(1, 4, 1'b1, 0, 20);
        send_pkt(1, 2, 1'b1, 0, 21);
        repeat (3) tick();
        out_log.delete();
        pktout_ready = 1'b1;
        wait_cnt(6, 100, "t3_timeout");
        tick();
`ifdef PKT_MUX_PRIO_EN
        exp_ord = '{10, 11, 20, 21};
`else
        exp_ord = '{10, 20, 11, 21};
`endif
        chk("t3_npkts", out_log.size(), 4);
        for (int k = 0; k < out_log.size() && k < 4; k++) chk("t3_order", out_log[k], exp_ord[k]);

        // Backpressure for 3 cycles after the 2nd word
        out_words.delete();
        out_cyc.delete();
        send_pkt(0, 6, 1'b1, 0, 30);
        wait_words(2, "t4_wait_w2");
        pktout_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        pktout_ready = 1'b1;
        wait_cnt(7, 50, "t4_timeout");
        tick();
        chk("t4_len", out_words.size(), 6);
        for (int k = 0; k < out_words.size(); k++) chk("t4_word", out_words[k], mk_word(0, 30, k, 6));
        if (out_cyc.size() == 6) begin
            chk("t4_gap_w1_w2", out_cyc[1] - out_cyc[0], 1);
            chk("t4_stall", out_cyc[2] - out_cyc[1], 4);
            chk("t4_resume", out_cyc[5] - out_cyc[2], 3);
        end

        // Almost full: 224 stored words leaves 32 free
        pktout_ready = 1'b0;
        for (int k = 0; k < 224; k++) begin
            set_in(0, 1'b1, mk_word(0, 40, k, 224), 1'b1, 1'b0);
            tick();
        end
        set_in(0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_alf_223", in0_alf, 1'b0);
        @(negedge clk);
        chk("t5_alf_224", in0_alf, 1'b1);
        tick();
        set_in(0, 1'b0, '0, 1'b1, 1'b1);
        tick();
        set_in(0, 1'b0, '0, 1'b0, 1'b0);
        pktout_ready = 1'b1;
        wait_cnt(8, 400, "t5_timeout");
        repeat (3) tick();
        chk("t5_alf_drained", in0_alf, 1'b0);

        // Reset during word 3 of a 6-word packet
        out_words.delete();
        send_pkt(0, 6, 1'b1, 0, 50);
        wait_words(3, "t6_wait_w3");
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_data_wr", pktout_data_wr, 1'b0);
        chk("t6_data", pktout_data, '0);
        chk("t6_valid", {pktout_data_valid, pktout_data_valid_wr}, 2'b00);
        chk("t6_cnt", out_pkt_cnt, '0);
        tick();
        out_words.delete();
        send_pkt(0, 5, 1'b1, 0, 51);
        wait_cnt(1, 50, "t6_timeout");
        repeat (3) tick();
        chk("t6_len", out_words.size(), 5);
        for (int k = 0; k < out_words.size(); k++) chk("t6_word", out_words[k], mk_word(0, 51, k, 5));

        // Randomized traffic on both inputs with random backpressure
        base = int'(out_pkt_cnt);
        n_good = 0;
        fork
            begin
                fork
                    rnd_drv(0);
                    rnd_drv(1);
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    pktout_ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        pktout_ready = 1'b1;
        wait_cnt(base + n_good, 3000, "rnd_timeout");
        repeat (5) tick();
        chk("rnd_total", out_pkt_cnt, 32'(base + n_good));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
